// File: rtl/mc14500_program_loader_pkg.sv
// Shared loader types: FSM state encoding and the frame sync byte.
package mc14500_program_loader_pkg;

  localparam logic [7:0] LOADER_SYNC = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_WRITE,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } loader_state_t;

endpackage

// File: rtl/mc14500_program_loader.sv
// Byte-stream program loader: frames SYNC/LEN/data into ROM words, holds the core until done.
// Write strobe one cycle after the last byte of a word; in_ready low only during that write cycle.
// LOADER_CHECKSUM_EN adds a trailing XOR checksum byte (CHK state).
module mc14500_program_loader
  import mc14500_program_loader_pkg::*;
#(
  parameter int ADDR = 12,
  parameter int CODE = 4,
  parameter int WORD = ADDR + CODE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  output logic            in_ready,
  output logic            program_write,
  output logic [WORD-1:0] program_cmd,
  output logic [ADDR-1:0] program_addr,
  output logic            cpu_hold,
  output logic            done,
  output logic            error
);

  localparam int NB = (WORD + 7) / 8;
  localparam int AW = NB * 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR;

  loader_state_t   state_q, state_d;
  logic [7:0]      len_hi_q, len_hi_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [AW-1:0]   asm_q, asm_d;
  logic            rdy_q, rdy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic [15:0]     len_word;
  logic            xfer;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      chk_q, chk_d;
`endif

  assign xfer     = in_valid & rdy_q;
  assign len_word = {len_hi_q, in_data};

  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    done_d     = done_q;
    error_d    = error_q;
`ifdef LOADER_CHECKSUM_EN
    chk_d      = chk_q;
    if (xfer && (state_q == ST_LEN_HI || state_q == ST_LEN_LO || state_q == ST_DATA)) begin
      chk_d = chk_q ^ in_data;
    end
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (xfer && in_data == LOADER_SYNC) begin
          state_d = ST_LEN_HI;
          done_d  = 1'b0;
          error_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          chk_d   = 8'h00;
`endif
        end
      end
      ST_LEN_HI: begin
        if (xfer) begin
          len_hi_d = in_data;
          state_d  = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (xfer) begin
          if (len_word == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = ST_CHK;
`else
            state_d = ST_DONE;
            done_d  = 1'b1;
`endif
          end else if ({16'd0, len_word} > MAX_WORDS) begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end else begin
            addr_d     = '0;
            cnt_d      = len_word;
            byte_cnt_d = '0;
            state_d    = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (xfer) begin
          asm_d = (asm_q << 8) | AW'(in_data);
          if (byte_cnt_q == BW'(NB - 1)) begin
            byte_cnt_d = '0;
            state_d    = ST_WRITE;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      ST_WRITE: begin
        // Address wraps to 0 after the last legal word; no write follows it.
        addr_d = addr_q + 1'b1;
        cnt_d  = cnt_q - 16'd1;
        if (cnt_q == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = ST_CHK;
`else
          state_d = ST_DONE;
          done_d  = 1'b1;
`endif
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (xfer) begin
          if (in_data == chk_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    rdy_d = (state_d != ST_WRITE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      len_hi_q   <= 8'h00;
      cnt_q      <= 16'd0;
      addr_q     <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      rdy_q      <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      rdy_q      <= rdy_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef LOADER_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  // Only a successful load releases the core.
  assign cpu_hold      = ~done_q;
  assign in_ready      = rdy_q;
  assign program_write = (state_q == ST_WRITE);
  assign program_cmd   = asm_q[WORD-1:0];
  assign program_addr  = addr_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_mc14500_program_loader.sv
// Directed-vector bench for mc14500_program_loader (default and checksum builds).
module tb_mc14500_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        program_write;
  logic [15:0] program_cmd;
  logic [11:0] program_addr;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] wq_cmd[$];
  logic [11:0] wq_addr[$];
  bit          mon_rdy = 1'b0;
  int          rdy_bad = 0;

  mc14500_program_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .program_write(program_write), .program_cmd(program_cmd), .program_addr(program_addr),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (program_write === 1'b1) begin
      wq_cmd.push_back(program_cmd);
      wq_addr.push_back(program_addr);
    end
    if (mon_rdy && (in_ready !== ~program_write)) rdy_bad++;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int  n;
    logic r;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    do begin
      r = in_ready;
      @(negedge clk);
      n++;
    end while (!r && n < 100);
    in_valid = 1'b0;
    if (!r) begin
      vectors++; miscompares++;
      $display("FAIL send_byte_timeout: byte %h, in_ready stayed 0, required 1", b);
    end
  endtask

  task automatic send_frame(input logic [7:0] fr[$], input int maxgap);
    foreach (fr[i]) send_byte(fr[i], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
  endtask

  function automatic void clear_writes();
    wq_cmd.delete();
    wq_addr.delete();
  endfunction

  task automatic test_reset();
    #12;
    vectors++; if (in_ready !== 1'b0)       begin miscompares++; $display("FAIL rst_in_ready: got %b, want 0", in_ready); end
    vectors++; if (program_write !== 1'b0)  begin miscompares++; $display("FAIL rst_write: got %b, want 0", program_write); end
    vectors++; if (program_cmd !== 16'h0)   begin miscompares++; $display("FAIL rst_cmd: got %h, want 0000", program_cmd); end
    vectors++; if (program_addr !== 12'h0)  begin miscompares++; $display("FAIL rst_addr: got %h, want 000", program_addr); end
    vectors++; if (cpu_hold !== 1'b1)       begin miscompares++; $display("FAIL rst_hold: got %b, want 1", cpu_hold); end
    vectors++; if (done !== 1'b0)           begin miscompares++; $display("FAIL rst_done: got %b, want 0", done); end
    vectors++; if (error !== 1'b0)          begin miscompares++; $display("FAIL rst_error: got %b, want 0", error); end
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (in_ready !== 1'b1)       begin miscompares++; $display("FAIL rst_release_ready: got %b, want 1", in_ready); end
  endtask

  task automatic load_two_words(input string tag, input int maxgap);
    logic [7:0] fr[$];
    fr = '{8'hA5, 8'h00, 8'h02, 8'h10, 8'h05, 8'hE0, 8'hFF};
`ifdef LOADER_CHECKSUM_EN
    fr.push_back(8'h08);
`endif
    clear_writes();
    send_frame(fr, maxgap);
    repeat (3) @(negedge clk);
    vectors++; if (wq_cmd.size() != 2) begin miscompares++; $display("FAIL %s_count: got %0d writes, want 2", tag, wq_cmd.size()); end
    if (wq_cmd.size() == 2) begin
      vectors++; if (wq_cmd[0] !== 16'h1005 || wq_addr[0] !== 12'h000) begin miscompares++; $display("FAIL %s_w0: got %h@%h, want 1005@000", tag, wq_cmd[0], wq_addr[0]); end
      vectors++; if (wq_cmd[1] !== 16'hE0FF || wq_addr[1] !== 12'h001) begin miscompares++; $display("FAIL %s_w1: got %h@%h, want e0ff@001", tag, wq_cmd[1], wq_addr[1]); end
    end
    vectors++; if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0) begin miscompares++; $display("FAIL %s_status: got done=%b hold=%b err=%b, want 1 0 0", tag, done, cpu_hold, error); end
    vectors++; if (program_addr !== 12'h002) begin miscompares++; $display("FAIL %s_addr: got %h, want 002", tag, program_addr); end
  endtask

  task automatic test_load();
    load_two_words("load", 0);
  endtask

  task automatic test_empty();
    clear_writes();
    send_byte(8'hA5, 0);
    vectors++; if (done !== 1'b0 || cpu_hold !== 1'b1) begin miscompares++; $display("FAIL empty_sync_clears: got done=%b hold=%b, want 0 1", done, cpu_hold); end
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    vectors++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin miscompares++; $display("FAIL empty_done: got done=%b hold=%b, want 1 0", done, cpu_hold); end
    repeat (3) @(negedge clk);
    vectors++; if (wq_cmd.size() != 0) begin miscompares++; $display("FAIL empty_nowrite: got %0d writes, want 0", wq_cmd.size()); end
  endtask

  task automatic test_too_long();
    clear_writes();
    send_frame('{8'hA5, 8'h10, 8'h01}, 0);
    repeat (3) @(negedge clk);
    vectors++; if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL toolong_status: got err=%b hold=%b done=%b, want 1 1 0", error, cpu_hold, done); end
    vectors++; if (wq_cmd.size() != 0) begin miscompares++; $display("FAIL toolong_nowrite: got %0d writes, want 0", wq_cmd.size()); end
    send_frame('{8'hA5, 8'h00, 8'h00}, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    vectors++; if (error !== 1'b0 || done !== 1'b1) begin miscompares++; $display("FAIL toolong_recover: got err=%b done=%b, want 0 1", error, done); end
  endtask

  task automatic test_gaps();
    rdy_bad = 0;
    mon_rdy = 1'b1;
    load_two_words("gaps", 3);
    mon_rdy = 1'b0;
    vectors++; if (rdy_bad != 0) begin miscompares++; $display("FAIL gaps_ready: %0d cycles with in_ready != !program_write, want 0", rdy_bad); end
  endtask

  task automatic test_max_len();
    int bad;
    clear_writes();
    send_frame('{8'hA5, 8'h10, 8'h00}, 0);
    for (int i = 0; i < 4096; i++) begin
      send_byte(8'(i >> 8), 0);
      send_byte(8'(i), 0);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h10, 0);
`endif
    repeat (3) @(negedge clk);
    vectors++; if (wq_cmd.size() != 4096) begin miscompares++; $display("FAIL max_count: got %0d writes, want 4096", wq_cmd.size()); end
    bad = 0;
    foreach (wq_cmd[i]) if (wq_cmd[i] !== 16'(i) || wq_addr[i] !== 12'(i)) bad++;
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL max_content: %0d wrong words, want 0", bad); end
    vectors++; if (program_addr !== 12'h000 || done !== 1'b1) begin miscompares++; $display("FAIL max_end: got addr=%h done=%b, want 000 1", program_addr, done); end
  endtask

  task automatic test_reset_mid();
    send_frame('{8'hA5, 8'h00, 8'h02, 8'h10}, 0);
    rst = 1'b0;
    #1;
    vectors++; if (in_ready !== 1'b0 || program_write !== 1'b0) begin miscompares++; $display("FAIL midrst_flow: got rdy=%b wr=%b, want 0 0", in_ready, program_write); end
    vectors++; if (program_cmd !== 16'h0 || program_addr !== 12'h0) begin miscompares++; $display("FAIL midrst_data: got cmd=%h addr=%h, want 0000 000", program_cmd, program_addr); end
    vectors++; if (cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin miscompares++; $display("FAIL midrst_status: got hold=%b done=%b err=%b, want 1 0 0", cpu_hold, done, error); end
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    load_two_words("midrst_reload", 0);
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_bad_chk();
    clear_writes();
    send_frame('{8'hA5, 8'h00, 8'h02, 8'h10, 8'h05, 8'hE0, 8'hFF, 8'h00}, 0);
    repeat (3) @(negedge clk);
    vectors++; if (wq_cmd.size() != 2) begin miscompares++; $display("FAIL badchk_count: got %0d writes, want 2", wq_cmd.size()); end
    vectors++; if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL badchk_status: got err=%b hold=%b done=%b, want 1 1 0", error, cpu_hold, done); end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_empty();
    test_too_long();
    test_gaps();
    test_max_len();
    test_reset_mid();
`ifdef LOADER_CHECKSUM_EN
    test_bad_chk();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
